// File: rtl/chip_id_reader.sv
// chip_id_reader: reads the 64-bit device ID from the chipid block after reset
// (and on refresh), with a bounded wait for data_valid, and exposes the ID and
// status through a single-outstanding valid/ready register-read port.
// Optional build macro: CHIPID_RETRY_EN (retry a timed-out read up to 3 times).
`timescale 1ns/1ps

module chip_id_reader #(
    parameter int unsigned STARTUP_DELAY = 16,
    parameter int unsigned TIMEOUT       = 1024,
    parameter int unsigned CNT_W         = 16
) (
    input  logic        CLK,
    input  logic        RST_N,
    output logic        chipid_readid,
    input  logic        chipid_data_valid,
    input  logic [63:0] chipid_chip_id,
    input  logic        refresh,
    input  logic        rd_req_valid,
    output logic        rd_req_ready,
    input  logic [1:0]  rd_req_addr,
    output logic        rd_rsp_valid,
    input  logic        rd_rsp_ready,
    output logic [31:0] rd_rsp_data,
    output logic        id_valid,
    output logic        id_error
);

    localparam int unsigned ID_W   = 64;
    localparam int unsigned DATA_W = 32;

    localparam logic [CNT_W-1:0]  START_CNT    = CNT_W'(STARTUP_DELAY);
    localparam logic [CNT_W-1:0]  TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE      = CNT_W'(1);
    localparam logic [DATA_W-1:0] MAGIC        = 32'h43484944;

    typedef enum logic [2:0] {
        ST_START_WAIT = 3'd0,
        ST_REQ        = 3'd1,
        ST_WAIT_VALID = 3'd2,
        ST_DONE       = 3'd3,
        ST_ERROR      = 3'd4
    } state_e;

    state_e            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [ID_W-1:0]   id_q;
    logic              id_valid_q;
    logic              id_error_q;
    logic              readid_q;
    logic              retry_exh;

`ifdef CHIPID_RETRY_EN
    logic [1:0]        retry_q;
    logic              retry_exh_q;

    assign retry_exh = retry_exh_q;
`else
    assign retry_exh = 1'b0;
`endif

    // Read sequencer: startup delay, one-cycle readid, bounded wait, capture.
    // readid_q is set on every transition into REQ so it is high exactly
    // for the cycle the FSM sits in REQ.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= ST_START_WAIT;
            cnt_q       <= '0;
            id_q        <= '0;
            id_valid_q  <= 1'b0;
            id_error_q  <= 1'b0;
            readid_q    <= 1'b0;
`ifdef CHIPID_RETRY_EN
            retry_q     <= 2'd0;
            retry_exh_q <= 1'b0;
`endif
        end else begin
            readid_q <= 1'b0;
            case (state_q)
                ST_START_WAIT: begin
                    if (cnt_q == START_CNT) begin
                        state_q  <= ST_REQ;
                        cnt_q    <= '0;
                        readid_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                ST_REQ: begin
                    state_q <= ST_WAIT_VALID;
                    cnt_q   <= '0;
                end
                ST_WAIT_VALID: begin
                    // data_valid has priority over a coincident timeout
                    if (chipid_data_valid) begin
                        id_q       <= chipid_chip_id;
                        id_valid_q <= 1'b1;
                        id_error_q <= 1'b0;
                        state_q    <= ST_DONE;
`ifdef CHIPID_RETRY_EN
                        retry_q    <= 2'd0;
`endif
                    end else if (cnt_q == TIMEOUT_LAST) begin
`ifdef CHIPID_RETRY_EN
                        if (retry_q == 2'd3) begin
                            id_error_q  <= 1'b1;
                            retry_exh_q <= 1'b1;
                            state_q     <= ST_ERROR;
                        end else begin
                            retry_q  <= retry_q + 2'd1;
                            cnt_q    <= '0;
                            state_q  <= ST_REQ;
                            readid_q <= 1'b1;
                        end
`else
                        id_error_q <= 1'b1;
                        state_q    <= ST_ERROR;
`endif
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                ST_DONE, ST_ERROR: begin
                    // refresh re-reads immediately; the stale ID stays in id_q
                    if (refresh) begin
                        id_valid_q  <= 1'b0;
                        id_error_q  <= 1'b0;
                        cnt_q       <= '0;
                        state_q     <= ST_REQ;
                        readid_q    <= 1'b1;
`ifdef CHIPID_RETRY_EN
                        retry_q     <= 2'd0;
                        retry_exh_q <= 1'b0;
`endif
                    end
                end
                default: begin
                    state_q <= ST_START_WAIT;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    // Register-read side: status word and address decode
    logic              busy_c;
    logic [DATA_W-1:0] status_c;
    logic [DATA_W-1:0] reg_sel_c;

    assign busy_c   = (state_q == ST_START_WAIT) || (state_q == ST_REQ) ||
                      (state_q == ST_WAIT_VALID);
    assign status_c = {28'b0, busy_c, retry_exh, id_error_q, id_valid_q};

    // Address decode; the ID reads as zero until a capture is valid
    always_comb begin
        reg_sel_c = '0;
        case (rd_req_addr)
            2'd0:    reg_sel_c = id_valid_q ? id_q[31:0]  : '0;
            2'd1:    reg_sel_c = id_valid_q ? id_q[63:32] : '0;
            2'd2:    reg_sel_c = status_c;
            2'd3:    reg_sel_c = MAGIC;
            default: reg_sel_c = '0;
        endcase
    end

    logic              rsp_valid_q;
    logic              rsp_valid_d;
    logic [DATA_W-1:0] rsp_data_q;
    logic [DATA_W-1:0] rsp_data_d;
    logic              req_ready_q;

    // Single-outstanding handshake: accept only while no response is held
    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        if (rsp_valid_q) begin
            if (rd_rsp_ready) begin
                rsp_valid_d = 1'b0;
            end
        end else if (rd_req_valid) begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = reg_sel_c;
        end
    end

    // Response registers; ready is kept as the registered inverse of valid
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            req_ready_q <= 1'b1;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            req_ready_q <= !rsp_valid_d;
        end
    end

    assign chipid_readid = readid_q;
    assign id_valid      = id_valid_q;
    assign id_error      = id_error_q;
    assign rd_req_ready  = req_ready_q;
    assign rd_rsp_valid  = rsp_valid_q;
    assign rd_rsp_data   = rsp_data_q;

endmodule

// File: tb/tb_chip_id_reader.sv
// Self-checking bench for chip_id_reader (STARTUP_DELAY=16, TIMEOUT=8).
// Register reads push their expected data into a queue when the request is
// driven; the data is popped and compared when the response is presented.
`timescale 1ns/1ps

module tb_chip_id_reader;

    localparam int unsigned STARTUP_DELAY = 16;
    localparam int unsigned TIMEOUT       = 8;
    localparam int unsigned CNT_W         = 16;
    localparam int unsigned ATTEMPT_CYC   = TIMEOUT + 1;
    localparam logic [31:0] MAGIC         = 32'h43484944;
`ifdef CHIPID_RETRY_EN
    localparam int unsigned ATTEMPTS      = 4;
    localparam logic [31:0] ERR_STATUS    = 32'h6;
`else
    localparam int unsigned ATTEMPTS      = 1;
    localparam logic [31:0] ERR_STATUS    = 32'h2;
`endif

    logic        CLK   = 1'b0;
    logic        RST_N = 1'b0;
    logic        chipid_readid;
    logic        chipid_data_valid = 1'b0;
    logic [63:0] chipid_chip_id    = '0;
    logic        refresh           = 1'b0;
    logic        rd_req_valid      = 1'b0;
    logic        rd_req_ready;
    logic [1:0]  rd_req_addr       = 2'd0;
    logic        rd_rsp_valid;
    logic        rd_rsp_ready      = 1'b0;
    logic [31:0] rd_rsp_data;
    logic        id_valid;
    logic        id_error;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] exp_q [$];

    always #5 CLK = ~CLK;

    chip_id_reader #(
        .STARTUP_DELAY(STARTUP_DELAY),
        .TIMEOUT      (TIMEOUT),
        .CNT_W        (CNT_W)
    ) dut (
        .CLK              (CLK),
        .RST_N            (RST_N),
        .chipid_readid    (chipid_readid),
        .chipid_data_valid(chipid_data_valid),
        .chipid_chip_id   (chipid_chip_id),
        .refresh          (refresh),
        .rd_req_valid     (rd_req_valid),
        .rd_req_ready     (rd_req_ready),
        .rd_req_addr      (rd_req_addr),
        .rd_rsp_valid     (rd_rsp_valid),
        .rd_rsp_ready     (rd_rsp_ready),
        .rd_rsp_data      (rd_rsp_data),
        .id_valid         (id_valid),
        .id_error         (id_error)
    );

    // advance one clock; inputs are driven and outputs sampled 1ns after the edge
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // present one read request; on return the response should be pending
    task automatic issue_read(input logic [1:0] addr, input logic [31:0] exp);
        rd_req_valid = 1'b1;
        rd_req_addr  = addr;
        exp_q.push_back(exp);
        tick();
        rd_req_valid = 1'b0;
    endtask

    // consume the pending response
    task automatic finish_rsp();
        rd_rsp_ready = 1'b1;
        tick();
        rd_rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        tick();
        tick();
        n_tests++;
        if ({chipid_readid, id_valid, id_error, rd_rsp_valid, rd_req_ready} !== 5'b00001) begin
            n_fail++;
            $display("FAIL reset_ctrl got {readid,id_valid,id_error,rsp_valid,req_ready}=%b want 00001",
                     {chipid_readid, id_valid, id_error, rd_rsp_valid, rd_req_ready});
        end
        n_tests++;
        if (rd_rsp_data !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_data got %h want 00000000", rd_rsp_data);
        end
    endtask

    task automatic test_startup();
        int          pulses   = 0;
        int          first_rd = -1;
        int          first_v  = -1;
        logic [1:0]  addrs [4] = '{2'd0, 2'd1, 2'd2, 2'd3};
        logic [31:0] datas [4] = '{32'hdeadbeef, 32'h0, 32'h1, MAGIC};
        logic [31:0] exp;
        chipid_data_valid = 1'b1;
        chipid_chip_id    = 64'h00000000_deadbeef;
        RST_N             = 1'b1;
        for (int c = 0; c < 25; c++) begin
            tick();
            if (chipid_readid === 1'b1) begin
                pulses++;
                if (first_rd < 0) first_rd = c;
            end
            if (id_valid === 1'b1 && first_v < 0) first_v = c;
        end
        n_tests++;
        if (pulses != 1 || first_rd != 16) begin
            n_fail++;
            $display("FAIL startup_readid got pulses=%0d first_cycle=%0d want pulses=1 cycle=16", pulses, first_rd);
        end
        n_tests++;
        if (first_v != 18) begin
            n_fail++;
            $display("FAIL startup_id_valid got cycle=%0d want 18", first_v);
        end
        for (int i = 0; i < 4; i++) begin
            issue_read(addrs[i], datas[i]);
            exp = exp_q.pop_front();
            n_tests++;
            if (rd_rsp_valid !== 1'b1 || rd_rsp_data !== exp) begin
                n_fail++;
                $display("FAIL startup_read addr=%0d got valid=%b data=%h want valid=1 data=%h",
                         addrs[i], rd_rsp_valid, rd_rsp_data, exp);
            end
            finish_rsp();
        end
    endtask

    task automatic test_refresh();
        logic [1:0]  addrs [3] = '{2'd1, 2'd0, 2'd2};
        logic [31:0] datas [3] = '{32'h12345678, 32'h9abcdef0, 32'h1};
        logic [31:0] exp;
        chipid_chip_id = 64'h12345678_9abcdef0;
        refresh        = 1'b1;
        tick();
        refresh        = 1'b0;
        n_tests++;
        if (id_valid !== 1'b0 || chipid_readid !== 1'b1) begin
            n_fail++;
            $display("FAIL refresh_start got id_valid=%b readid=%b want id_valid=0 readid=1", id_valid, chipid_readid);
        end
        tick();
        tick();
        n_tests++;
        if (id_valid !== 1'b1 || chipid_readid !== 1'b0) begin
            n_fail++;
            $display("FAIL refresh_done got id_valid=%b readid=%b want id_valid=1 readid=0", id_valid, chipid_readid);
        end
        for (int i = 0; i < 3; i++) begin
            issue_read(addrs[i], datas[i]);
            exp = exp_q.pop_front();
            n_tests++;
            if (rd_rsp_valid !== 1'b1 || rd_rsp_data !== exp) begin
                n_fail++;
                $display("FAIL refresh_read addr=%0d got valid=%b data=%h want valid=1 data=%h",
                         addrs[i], rd_rsp_valid, rd_rsp_data, exp);
            end
            finish_rsp();
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] exp;
        issue_read(2'd3, MAGIC);
        exp = exp_q.pop_front();
        for (int c = 0; c < 5; c++) begin
            n_tests++;
            if (rd_rsp_valid !== 1'b1 || rd_rsp_data !== exp || rd_req_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_hold cycle=%0d got valid=%b data=%h req_ready=%b want valid=1 data=%h req_ready=0",
                         c, rd_rsp_valid, rd_rsp_data, rd_req_ready, exp);
            end
            tick();
        end
        // response accepted while a new request is already presented
        rd_rsp_ready = 1'b1;
        rd_req_valid = 1'b1;
        rd_req_addr  = 2'd2;
        exp_q.push_back(32'h1);
        tick();
        rd_rsp_ready = 1'b0;
        n_tests++;
        if (rd_rsp_valid !== 1'b0 || rd_req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_release got valid=%b req_ready=%b want valid=0 req_ready=1", rd_rsp_valid, rd_req_ready);
        end
        tick();
        rd_req_valid = 1'b0;
        exp = exp_q.pop_front();
        n_tests++;
        if (rd_rsp_valid !== 1'b1 || rd_rsp_data !== exp) begin
            n_fail++;
            $display("FAIL stall_next_req got valid=%b data=%h want valid=1 data=%h", rd_rsp_valid, rd_rsp_data, exp);
        end
        finish_rsp();
    endtask

    task automatic test_timeout();
        int          pulses    = 0;
        int          first_err = -1;
        logic [1:0]  addrs [3] = '{2'd2, 2'd0, 2'd1};
        logic [31:0] datas [3] = '{ERR_STATUS, 32'h0, 32'h0};
        logic [31:0] exp;
        chipid_data_valid = 1'b0;
        refresh           = 1'b1;
        tick();
        refresh           = 1'b0;
        if (chipid_readid === 1'b1) pulses++;
        for (int c = 1; c <= 50; c++) begin
            tick();
            refresh = (c == 3);   // lands in WAIT_VALID and must be ignored
            if (chipid_readid === 1'b1) pulses++;
            if (id_error === 1'b1 && first_err < 0) first_err = c;
        end
        refresh = 1'b0;
        n_tests++;
        if (pulses != int'(ATTEMPTS)) begin
            n_fail++;
            $display("FAIL timeout_pulses got %0d want %0d", pulses, ATTEMPTS);
        end
        n_tests++;
        if (first_err != int'(ATTEMPTS * ATTEMPT_CYC)) begin
            n_fail++;
            $display("FAIL timeout_error_cycle got %0d want %0d", first_err, ATTEMPTS * ATTEMPT_CYC);
        end
        n_tests++;
        if (id_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_id_valid got %b want 0", id_valid);
        end
        for (int i = 0; i < 3; i++) begin
            issue_read(addrs[i], datas[i]);
            exp = exp_q.pop_front();
            n_tests++;
            if (rd_rsp_valid !== 1'b1 || rd_rsp_data !== exp) begin
                n_fail++;
                $display("FAIL timeout_read addr=%0d got valid=%b data=%h want valid=1 data=%h",
                         addrs[i], rd_rsp_valid, rd_rsp_data, exp);
            end
            finish_rsp();
        end
    endtask

    task automatic test_reset_mid();
        int          pulses   = 0;
        int          first_rd = -1;
        int          first_v  = -1;
        logic [31:0] exp;
        // re-read with data_valid low, then leave a response pending in WAIT_VALID
        refresh = 1'b1;
        tick();
        refresh = 1'b0;
        tick();
        issue_read(2'd3, MAGIC);
        n_tests++;
        if (rd_rsp_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_pending got valid=%b want 1", rd_rsp_valid);
        end
        #2 RST_N = 1'b0;
        #1;
        n_tests++;
        if ({chipid_readid, id_valid, id_error, rd_rsp_valid, rd_req_ready} !== 5'b00001 ||
            rd_rsp_data !== 32'h0) begin
            n_fail++;
            $display("FAIL midrst_outputs got {readid,id_valid,id_error,rsp_valid,req_ready}=%b data=%h want 00001 data=00000000",
                     {chipid_readid, id_valid, id_error, rd_rsp_valid, rd_req_ready}, rd_rsp_data);
        end
        exp_q.delete();   // the pending response is dropped by reset
        chipid_data_valid = 1'b1;
        tick();
        RST_N = 1'b1;
        for (int c = 0; c < 25; c++) begin
            tick();
            if (chipid_readid === 1'b1) begin
                pulses++;
                if (first_rd < 0) first_rd = c;
            end
            if (id_valid === 1'b1 && first_v < 0) first_v = c;
        end
        n_tests++;
        if (pulses != 1 || first_rd != 16 || first_v != 18) begin
            n_fail++;
            $display("FAIL midrst_restart got pulses=%0d readid_cycle=%0d valid_cycle=%0d want 1/16/18",
                     pulses, first_rd, first_v);
        end
        issue_read(2'd0, 32'h9abcdef0);
        exp = exp_q.pop_front();
        n_tests++;
        if (rd_rsp_valid !== 1'b1 || rd_rsp_data !== exp) begin
            n_fail++;
            $display("FAIL midrst_read got valid=%b data=%h want valid=1 data=%h", rd_rsp_valid, rd_rsp_data, exp);
        end
        finish_rsp();
    endtask

    initial begin
        test_reset();
        test_startup();
        test_refresh();
        test_backpressure();
        test_timeout();
        test_reset_mid();
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain got %0d entries left want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
